// File: rtl/rst_seq_gen.sv
// Reset sequencer: holds RSTN_OUT low ASSERT_CYCLES edges, raises RST_DONE RELEASE_DELAY edges later, re-issues on request.
// All outputs registered (one-edge latency); HOLD_REQ stretches reset. Define RST_SEQ_WDOG_EN to add the S_RUN watchdog.
module rst_seq_gen #(
  parameter int ASSERT_CYCLES = 8,
  parameter int RELEASE_DELAY = 4,
  parameter int CNT_W         = 8,
  parameter int WDOG_CYCLES   = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SW_RST_REQ,
  input  logic             HOLD_REQ,
`ifdef RST_SEQ_WDOG_EN
  input  logic             WDOG_KICK,
  output logic             WDOG_FIRED,
`endif
  output logic             RSTN_OUT,
  output logic             RST_DONE,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] RST_CNT
);

  localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (ASSERT_CYCLES < 1 || RELEASE_DELAY < 1) begin : g_bad_cycles
    $error("rst_seq_gen: ASSERT_CYCLES and RELEASE_DELAY must be >= 1");
  end

  if (ASSERT_CYCLES > CNT_MAX || RELEASE_DELAY > CNT_MAX || WDOG_CYCLES > CNT_MAX) begin : g_bad_width
    $error("rst_seq_gen: CNT_W too narrow for configured cycle counts");
  end

  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(RELEASE_DELAY - 1);

  typedef enum logic [1:0] {
    S_ASSERT = 2'd0,
    S_WAIT   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wdog_to;
  logic             reissue;
  logic             rstn_nxt;
  logic             done_nxt;

  // A re-issue request only counts once the downstream reset has been released.
  assign reissue = (state == S_SETTLE || state == S_RUN) && (SW_RST_REQ || wdog_to);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_ASSERT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_ASSERT: begin
        if (cnt == ASSERT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = HOLD_REQ ? S_WAIT : S_SETTLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (!HOLD_REQ) begin
          cnt_nxt   = '0;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (reissue) begin
          cnt_nxt   = '0;
          state_nxt = S_ASSERT;
        end else if (cnt == SETTLE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (reissue) begin
          cnt_nxt   = '0;
          state_nxt = S_ASSERT;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_ASSERT;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with STATE.
  always_comb begin
    rstn_nxt = (state_nxt == S_SETTLE) || (state_nxt == S_RUN);
    done_nxt = (state_nxt == S_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      RSTN_OUT <= 1'b0;
      RST_DONE <= 1'b0;
      RST_CNT  <= '0;
    end else begin
      cnt      <= cnt_nxt;
      RSTN_OUT <= rstn_nxt;
      RST_DONE <= done_nxt;
      if (reissue && (RST_CNT != {CNT_W{1'b1}})) begin
        RST_CNT <= RST_CNT + 1'b1;
      end
    end
  end

  assign STATE = state;

`ifdef RST_SEQ_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] wdog_cnt;

  assign wdog_to = (state == S_RUN) && !WDOG_KICK && (wdog_cnt == WDOG_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wdog_cnt   <= '0;
      WDOG_FIRED <= 1'b0;
    end else begin
      if (state != S_RUN || WDOG_KICK || reissue) begin
        wdog_cnt <= '0;
      end else begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
      if (wdog_to) begin
        WDOG_FIRED <= 1'b1;
      end
    end
  end
`else
  assign wdog_to = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: reset, hold, SW re-issue, saturation, mid-sequence reset, optional watchdog.
module tb_rst_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_rst_req;
  logic       hold_req;
  logic       rstn_out;
  logic       rst_done;
  logic [1:0] state;
  logic [7:0] rst_cnt;
`ifdef RST_SEQ_WDOG_EN
  logic       wdog_kick;
  logic       wdog_fired;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  rst_seq_gen #(
    .ASSERT_CYCLES(8),
    .RELEASE_DELAY(4),
    .CNT_W        (8),
    .WDOG_CYCLES  (16)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .SW_RST_REQ(sw_rst_req),
    .HOLD_REQ  (hold_req),
`ifdef RST_SEQ_WDOG_EN
    .WDOG_KICK (wdog_kick),
    .WDOG_FIRED(wdog_fired),
`endif
    .RSTN_OUT  (rstn_out),
    .RST_DONE  (rst_done),
    .STATE     (state),
    .RST_CNT   (rst_cnt)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    step(1);
    sw_rst_req = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    sw_rst_req = 1'b0;
    hold_req   = 1'b0;
`ifdef RST_SEQ_WDOG_EN
    wdog_kick  = 1'b0;
`endif

    // 1: reset values, then release timing
    step(3);
    chk("rst_rstn", 32'(rstn_out), 32'd0);
    chk("rst_done", 32'(rst_done), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", 32'(rst_cnt), 32'd0);
    rst = 1'b0;
    step(7);
    chk("t1_rstn_e7", 32'(rstn_out), 32'd0);
    chk("t1_state_e7", 32'(state), 32'd0);
    step(1);
    chk("t1_rstn_e8", 32'(rstn_out), 32'd1);
    chk("t1_state_e8", 32'(state), 32'd2);
    step(3);
    chk("t1_done_e11", 32'(rst_done), 32'd0);
    step(1);
    chk("t1_done_e12", 32'(rst_done), 32'd1);
    chk("t1_state_e12", 32'(state), 32'd3);

    // 2: HOLD_REQ stretches reset in S_WAIT
    rst      = 1'b1;
    hold_req = 1'b1;
    step(1);
    rst = 1'b0;
    step(20);
    chk("t2_state_wait", 32'(state), 32'd1);
    chk("t2_rstn_wait", 32'(rstn_out), 32'd0);
    hold_req = 1'b0;
    step(1);
    chk("t2_rstn_rel", 32'(rstn_out), 32'd1);
    chk("t2_state_rel", 32'(state), 32'd2);
    step(3);
    chk("t2_done_e3", 32'(rst_done), 32'd0);
    step(1);
    chk("t2_done_e4", 32'(rst_done), 32'd1);
    chk("t2_cnt", 32'(rst_cnt), 32'd0);

    // 3: SW re-issue from S_RUN; request during S_ASSERT is ignored
    sw_pulse();
    chk("t3_rstn", 32'(rstn_out), 32'd0);
    chk("t3_state", 32'(state), 32'd0);
    chk("t3_done", 32'(rst_done), 32'd0);
    chk("t3_cnt", 32'(rst_cnt), 32'd1);
    step(3);
    sw_pulse();
    chk("t3_ign_cnt", 32'(rst_cnt), 32'd1);
    chk("t3_ign_state", 32'(state), 32'd0);
    step(3);
    chk("t3_rstn_e7", 32'(rstn_out), 32'd0);
    step(1);
    chk("t3_rstn_e8", 32'(rstn_out), 32'd1);
    chk("t3_state_e8", 32'(state), 32'd2);
    step(3);
    chk("t3_done_e11", 32'(rst_done), 32'd0);
    step(1);
    chk("t3_done_e12", 32'(rst_done), 32'd1);

    // SW request in S_SETTLE also re-issues
    sw_pulse();
    chk("t3_cnt2", 32'(rst_cnt), 32'd2);
    step(8);
    chk("t3_settle", 32'(state), 32'd2);
    sw_pulse();
    chk("t3_settle_req_state", 32'(state), 32'd0);
    chk("t3_settle_req_rstn", 32'(rstn_out), 32'd0);
    chk("t3_cnt3", 32'(rst_cnt), 32'd3);
    step(12);
    chk("t3_back_run", 32'(state), 32'd3);

    // 4: 300 re-issues saturate the count
    exp_cnt = 3;
    for (int i = 0; i < 300; i++) begin
      sw_pulse();
      if (exp_cnt < 255) exp_cnt++;
      if (i == 100) chk("t4_cnt_mid", 32'(rst_cnt), 32'(exp_cnt));
      step(12);
    end
    chk("t4_cnt_sat", 32'(rst_cnt), 32'd255);
    chk("t4_state", 32'(state), 32'd3);

    // 5: RST in S_SETTLE clears everything and restarts
    sw_pulse();
    step(8);
    chk("t5_settle", 32'(state), 32'd2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_state", 32'(state), 32'd0);
    chk("t5_rstn", 32'(rstn_out), 32'd0);
    chk("t5_done", 32'(rst_done), 32'd0);
    chk("t5_cnt", 32'(rst_cnt), 32'd0);
    step(7);
    chk("t5_rstn_e7", 32'(rstn_out), 32'd0);
    step(1);
    chk("t5_rstn_e8", 32'(rstn_out), 32'd1);
    step(3);
    chk("t5_done_e11", 32'(rst_done), 32'd0);
    step(1);
    chk("t5_done_e12", 32'(rst_done), 32'd1);
    chk("t5_state_run", 32'(state), 32'd3);

    // HOLD_REQ is ignored in S_RUN
    hold_req = 1'b1;
    step(3);
    chk("t5_hold_run_state", 32'(state), 32'd3);
    chk("t5_hold_run_rstn", 32'(rstn_out), 32'd1);
    hold_req = 1'b0;

`ifdef RST_SEQ_WDOG_EN
    // 6: watchdog timeout and kick
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(12);
    chk("t6_run", 32'(state), 32'd3);
    chk("t6_fired0", 32'(wdog_fired), 32'd0);
    step(15);
    chk("t6_run_e15", 32'(state), 32'd3);
    step(1);
    chk("t6_to_state", 32'(state), 32'd0);
    chk("t6_to_fired", 32'(wdog_fired), 32'd1);
    chk("t6_to_cnt", 32'(rst_cnt), 32'd1);
    step(12);
    chk("t6_run2", 32'(state), 32'd3);
    chk("t6_sticky", 32'(wdog_fired), 32'd1);
    for (int i = 0; i < 200; i++) begin
      wdog_kick = ((i % 10) == 9);
      step(1);
      wdog_kick = 1'b0;
    end
    chk("t6_kick_state", 32'(state), 32'd3);
    chk("t6_kick_cnt", 32'(rst_cnt), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
